// File: rtl/boot_pkg.sv
// Shared types and constants for the program-image boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        HOLD,
        RUN,
        ERR
    } boot_state_e;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed byte image, packs little-endian
// words into instruction memory, then releases the core from reset.
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam int IDX_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(BYTES_PER_WORD);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    boot_state_e       state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic [15:0]       len_full;

    assign accept     = in_valid & in_ready_q;
    assign len_full   = {in_data, len_q[7:0]};

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign err        = err_q;

    // Next-state logic: length header, byte packing, reset hold, terminal states.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        idx_d        = idx_q;
        hold_cnt_d   = hold_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_rst_d   = core_rst_q;
        done_d       = done_q;
        err_d        = err_q;

        case (state_q)
            LEN0: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    hold_cnt_d  = '0;
                    if (len_full == 16'd0) begin
                        state_d = HOLD;
                    end else if ({1'b0, len_full} > CAPACITY) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    word_d[8*cnt_q +: 8] = in_data;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = idx_q[ADDR_W-1:0];
                        imem_wdata_d = word_d;
                        idx_d        = idx_q + IDX_W'(1);
                        if (17'(idx_q) + 17'd1 == {1'b0, len_q}) begin
                            state_d    = HOLD;
                            hold_cnt_d = '0;
                        end
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
                    state_d    = RUN;
                    core_rst_d = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                core_rst_d = 1'b0;
                done_d     = 1'b1;
            end
            ERR: begin
                core_rst_d = 1'b1;
                err_d      = 1'b1;
            end
            default: begin
                state_d = LEN0;
            end
        endcase

        in_ready_d = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
    end

    // State and output registers; reset discards any partial word and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LEN0;
            len_q        <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            idx_q        <= '0;
            hold_cnt_q   <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            hold_cnt_q   <= hold_cnt_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: a full-size instance (A) and a 4-word instance (B)
// share one clock; expected memory writes are queued when bytes are driven.
module tb_boot_loader;

    localparam int RST_HOLD = 4;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          tests = 0;
    int          errors = 0;

    logic        a_rst = 1'b1, a_in_valid = 1'b0;
    logic [7:0]  a_in_data = 8'h00;
    logic        a_in_ready, a_imem_we, a_core_rst, a_done, a_err;
    logic [7:0]  a_imem_addr;
    logic [31:0] a_imem_wdata;

    logic        b_rst = 1'b1, b_in_valid = 1'b0;
    logic [7:0]  b_in_data = 8'h00;
    logic        b_in_ready, b_imem_we, b_core_rst, b_done, b_err;
    logic [1:0]  b_imem_addr;
    logic [31:0] b_imem_wdata;

    wr_t         exp_a[$];
    wr_t         exp_b[$];
    int          a_strobes = 0;
    int          b_strobes = 0;
    int          accept_cyc = 0;

    boot_loader #(.ADDR_W(8), .RST_HOLD(RST_HOLD)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .imem_we(a_imem_we), .imem_addr(a_imem_addr),
        .imem_wdata(a_imem_wdata), .core_rst(a_core_rst), .done(a_done), .err(a_err)
    );

    boot_loader #(.ADDR_W(2), .RST_HOLD(RST_HOLD)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
        .imem_wdata(b_imem_wdata), .core_rst(b_core_rst), .done(b_done), .err(b_err)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (a_imem_we === 1'b1) begin
            a_strobes++;
            tests++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("[TB] FAIL a_unexpected_write: got addr %0d data %h, none expected", a_imem_addr, a_imem_wdata);
            end else begin
                wr_t e;
                e = exp_a.pop_front();
                if (a_imem_addr !== e.addr || a_imem_wdata !== e.data) begin
                    errors++;
                    $display("[TB] FAIL a_write: got addr %0d data %h, expected addr %0d data %h", a_imem_addr, a_imem_wdata, e.addr, e.data);
                end
            end
        end
        if (b_imem_we === 1'b1) begin
            b_strobes++;
            tests++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("[TB] FAIL b_unexpected_write: got addr %0d data %h, none expected", b_imem_addr, b_imem_wdata);
            end else begin
                wr_t e;
                e = exp_b.pop_front();
                if ({6'b0, b_imem_addr} !== e.addr || b_imem_wdata !== e.data) begin
                    errors++;
                    $display("[TB] FAIL b_write: got addr %0d data %h, expected addr %0d data %h", b_imem_addr, b_imem_wdata, e.addr, e.data);
                end
            end
        end
        tests++;
        if (a_done !== ~a_core_rst) begin
            errors++;
            $display("[TB] FAIL a_done_vs_core_rst: done %b core_rst %b, expected complementary", a_done, a_core_rst);
        end
    end

    // Drive one byte and hold it until the loader takes it.
    task automatic send_byte(input bit sel, input logic [7:0] b, input bit gap);
        int waited;
        bit got;
        waited = 0;
        got = 1'b0;
        if (sel) begin b_in_valid = 1'b1; b_in_data = b; end
        else     begin a_in_valid = 1'b1; a_in_data = b; end
        while (!got && waited < 50) begin
            @(negedge clk);
            if ((sel ? b_in_ready : a_in_ready) === 1'b1) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            tests++;
            errors++;
            $display("[TB] FAIL byte_timeout: in_ready %b after 50 cycles, expected 1", sel ? b_in_ready : a_in_ready);
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        if (sel) begin b_in_valid = 1'b0; b_in_data = 8'($urandom); end
        else     begin a_in_valid = 1'b0; a_in_data = 8'($urandom); end
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the expected write, then stream the word LSB first.
    task automatic send_word(input bit sel, input logic [7:0] addr, input logic [31:0] w, input bit gap);
        wr_t e;
        e.addr = addr;
        e.data = w;
        if (sel) exp_b.push_back(e);
        else     exp_a.push_back(e);
        for (int i = 0; i < 4; i++) send_byte(sel, w[8*i +: 8], gap);
    endtask

    // Wait for core release and check it came RST_HOLD cycles after the last accepted byte.
    task automatic wait_release(input bit sel, input string name);
        int waited;
        waited = 0;
        while ((sel ? b_core_rst : a_core_rst) !== 1'b0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if ((sel ? b_core_rst : a_core_rst) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_release_timeout: core_rst %b, expected 0", name, sel ? b_core_rst : a_core_rst);
        end else if (cyc - accept_cyc != RST_HOLD) begin
            errors++;
            $display("[TB] FAIL %s_hold_time: released after %0d cycles, expected %0d", name, cyc - accept_cyc, RST_HOLD);
        end
        tests++;
        if ((sel ? b_done : a_done) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_done: got %b, expected 1", name, sel ? b_done : a_done);
        end
    endtask

    task automatic check_reset_values(input bit sel, input string name);
        logic [6:0] got;
        got = sel ? {b_in_ready, b_imem_we, |b_imem_addr, |b_imem_wdata, b_core_rst, b_done, b_err}
                  : {a_in_ready, a_imem_we, |a_imem_addr, |a_imem_wdata, a_core_rst, a_done, a_err};
        tests++;
        if (got !== 7'b0000100) begin
            errors++;
            $display("[TB] FAIL %s: {ready,we,addr!=0,wdata!=0,core_rst,done,err}=%b, expected 0000100", name, got);
        end
    endtask

    task automatic test_reset(input bit sel);
        if (sel) b_rst = 1'b1; else a_rst = 1'b1;
        #1;
        check_reset_values(sel, "reset_values");
        @(negedge clk);
        if (sel) b_rst = 1'b0; else a_rst = 1'b0;
        #1;
        tests++;
        if ((sel ? b_in_ready : a_in_ready) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_before_clock: got %b, expected 0", sel ? b_in_ready : a_in_ready);
        end
        @(posedge clk);
        #1;
        tests++;
        if ((sel ? b_in_ready : a_in_ready) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_clock: got %b, expected 1", sel ? b_in_ready : a_in_ready);
        end
    endtask

    task automatic check_drained(input string name, input int strobes, input int want);
        tests++;
        if (exp_a.size() != 0 || strobes != want) begin
            errors++;
            $display("[TB] FAIL %s_strobes: got %0d strobes (%0d pending), expected %0d", name, strobes, exp_a.size(), want);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        test_reset(1'b0);
        s0 = a_strobes;
        send_byte(1'b0, 8'h02, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_word(1'b0, 8'd0, 32'h00500013, 1'b0);
        send_word(1'b0, 8'd1, 32'h00100093, 1'b0);
        tests++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_after_last_word: got %b, expected 0", a_in_ready);
        end
        wait_release(1'b0, "b2b");
        check_drained("b2b", a_strobes - s0, 2);
    endtask

    task automatic test_bubbles();
        int s0;
        test_reset(1'b0);
        s0 = a_strobes;
        send_byte(1'b0, 8'h02, 1'b1);
        send_byte(1'b0, 8'h00, 1'b1);
        send_word(1'b0, 8'd0, 32'h00500013, 1'b1);
        send_word(1'b0, 8'd1, 32'h00100093, 1'b0);
        wait_release(1'b0, "bubbles");
        repeat (5) @(negedge clk);
        check_drained("bubbles", a_strobes - s0, 2);
    endtask

    task automatic test_zero_length();
        int s0;
        test_reset(1'b0);
        s0 = a_strobes;
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        wait_release(1'b0, "zero_len");
        check_drained("zero_len", a_strobes - s0, 0);
    endtask

    task automatic test_capacity();
        logic [31:0] w;
        test_reset(1'b1);
        send_byte(1'b1, 8'h05, 1'b0);
        send_byte(1'b1, 8'h00, 1'b0);
        b_in_valid = 1'b1;
        b_in_data  = 8'hAA;
        repeat (6) @(negedge clk);
        tests++;
        if ({b_err, b_core_rst, b_in_ready, b_done} !== 4'b1100 || b_strobes != 0) begin
            errors++;
            $display("[TB] FAIL overflow: {err,core_rst,ready,done}=%b strobes %0d, expected 1100 and 0", {b_err, b_core_rst, b_in_ready, b_done}, b_strobes);
        end
        b_in_valid = 1'b0;
        test_reset(1'b1);
        send_byte(1'b1, 8'h04, 1'b0);
        send_byte(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            send_word(1'b1, 8'(i), w, 1'b0);
        end
        wait_release(1'b1, "full");
        tests++;
        if (b_strobes != 4 || exp_b.size() != 0 || b_imem_addr !== 2'd3) begin
            errors++;
            $display("[TB] FAIL full_capacity: strobes %0d pending %0d last addr %0d, expected 4 0 3", b_strobes, exp_b.size(), b_imem_addr);
        end
    endtask

    task automatic test_abort_reload();
        int s0;
        test_reset(1'b0);
        s0 = a_strobes;
        send_byte(1'b0, 8'h02, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_word(1'b0, 8'd0, 32'hCAFEF00D, 1'b0);
        send_byte(1'b0, 8'h11, 1'b0);
        send_byte(1'b0, 8'h22, 1'b0);
        #2;
        a_rst = 1'b1;
        #1;
        check_reset_values(1'b0, "async_abort");
        check_drained("abort", a_strobes - s0, 1);
        s0 = a_strobes;
        @(negedge clk);
        a_rst = 1'b0;
        send_byte(1'b0, 8'h01, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_word(1'b0, 8'd0, 32'h12345678, 1'b0);
        wait_release(1'b0, "reload");
        check_drained("reload", a_strobes - s0, 1);
    endtask

    task automatic test_run_quiet();
        int s0;
        int bad;
        s0 = a_strobes;
        bad = 0;
        a_in_valid = 1'b1;
        a_in_data  = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_in_ready !== 1'b0 || a_done !== 1'b1) bad++;
        end
        a_in_valid = 1'b0;
        tests++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL run_quiet: %0d cycles with ready=1 or done=0, expected 0", bad);
        end
        check_drained("run_quiet", a_strobes - s0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_back_to_back();
        test_bubbles();
        test_zero_length();
        test_capacity();
        test_abort_reload();
        test_run_quiet();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
